// File: rtl/event_formatter_mc.sv
// Event formatter: drains one header block and per-channel FLAG/STOP/DATA words per event
// from the DRS4 channel FIFOs into a single downstream write port.
module event_formatter_mc #(
  parameter int NCH        = 8,
  parameter int DW         = 8,
  parameter int DEPTH_W    = 13,
  parameter int HDR_WORDS  = 32,
  parameter int FLAG_WORDS = 2,
  parameter int STOP_WORDS = 2,
  parameter int DATA_MULT  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DEPTH_W-1:0]   DRS_READDEPTH,
  input  logic [NCH-1:0]       CH_MASK,
  input  logic                 ORDER_MODE,
  output logic                 CFIFO_RDEN,
  input  logic                 CFIFO_EMPTY,
  input  logic                 CFIFO_VALID,
  input  logic [DW-1:0]        CFIFO_DOUT,
  output logic [NCH-1:0]       DFIFO_RDEN,
  input  logic [NCH-1:0]       DFIFO_EMPTY,
  input  logic [NCH-1:0]       DFIFO_VALID,
  input  logic [NCH*DW-1:0]    DFIFO_DOUT,
  input  logic                 OUT_AFULL,
  output logic                 OUT_WREN,
  output logic [DW-1:0]        OUT_DATA,
  output logic                 BUSY,
  output logic [15:0]          EVT_CNT,
  output logic                 ERR
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CW = $clog2(NCH);
  localparam int PW = DEPTH_W + 3;
  localparam int LW = max2(PW, max2($clog2(HDR_WORDS + 1),
                                    max2($clog2(FLAG_WORDS + 1), $clog2(STOP_WORDS + 1))));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_FLAG = 3'd2,
    S_STOP = 3'd3,
    S_DATA = 3'd4
  } state_t;

  state_t               state_r;
  logic [LW-1:0]        wc_r;
  logic [CW-1:0]        sel_r;
  logic [CW:0]          n_en_r;
  logic [CW-1:0]        list_r [NCH];
  logic [DEPTH_W-1:0]   depth_r;
  logic [15:0]          evt_cnt_r;
  logic                 busy_r;
  logic                 err_r;
  logic                 cfifo_rden_r;
  logic [NCH-1:0]       dfifo_rden_r;
  logic                 pend_c_r;
  logic [NCH-1:0]       pend_d_r;
  logic                 out_wren_r;
  logic [DW-1:0]        out_data_r;

  logic [CW-1:0]        list_s [NCH];
  logic [CW:0]          n_en_s;
  logic [CW-1:0]        ch_s;
  logic [CW-1:0]        chan_s;
  logic [PW-1:0]        data_lim_s;
  logic [LW-1:0]        limit_s;
  logic                 src_empty_s;
  logic                 go_s;
  logic                 last_s;
  logic                 phase_done_s;
  state_t               nxt_state_s;
  logic [DW-1:0]        word_s;
  logic                 valid_any_s;
  logic                 multi_s;
  logic                 orphan_s;

  // Build the compacted channel visiting order from the live config; latched at event start.
  always_comb begin
    list_s = '{default: '0};
    n_en_s = '0;
    ch_s   = '0;
    for (int j = 0; j < NCH; j++) begin
      ch_s = ORDER_MODE ? CW'((j < NCH / 2) ? 2 * j : 2 * (j - NCH / 2) + 1) : CW'(j);
      if (CH_MASK[ch_s]) begin
        list_s[n_en_s[CW-1:0]] = ch_s;
        n_en_s = n_en_s + (CW+1)'(1);
      end else begin
        n_en_s = n_en_s;
      end
    end
  end

  // Issue decision and end-of-phase detection for the current state and channel.
  always_comb begin
    chan_s      = list_r[sel_r];
    data_lim_s  = PW'(depth_r) * PW'(DATA_MULT);
    limit_s     = '0;
    src_empty_s = 1'b1;
    nxt_state_s = S_IDLE;
    case (state_r)
      S_HDR: begin
        limit_s     = LW'(HDR_WORDS);
        src_empty_s = CFIFO_EMPTY;
        nxt_state_s = (n_en_r == '0) ? S_IDLE : S_FLAG;
      end
      S_FLAG: begin
        limit_s     = LW'(FLAG_WORDS);
        src_empty_s = DFIFO_EMPTY[chan_s];
        nxt_state_s = S_STOP;
      end
      S_STOP: begin
        limit_s     = LW'(STOP_WORDS);
        src_empty_s = DFIFO_EMPTY[chan_s];
        nxt_state_s = (depth_r == '0) ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        limit_s     = LW'(data_lim_s);
        src_empty_s = DFIFO_EMPTY[chan_s];
        nxt_state_s = S_IDLE;
      end
      default: begin
        limit_s     = '0;
        src_empty_s = 1'b1;
        nxt_state_s = S_IDLE;
      end
    endcase
    go_s         = (state_r != S_IDLE) && !OUT_AFULL && !src_empty_s;
    last_s       = (wc_r == limit_s - LW'(1));
    phase_done_s = (state_r == S_HDR) || ((CW+1)'(sel_r) == n_en_r - (CW+1)'(1));
  end

  // Event sequencer: phase/channel walk, read strobes, event counter and busy flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= S_IDLE;
      wc_r         <= '0;
      sel_r        <= '0;
      n_en_r       <= '0;
      list_r       <= '{default: '0};
      depth_r      <= '0;
      evt_cnt_r    <= 16'd0;
      busy_r       <= 1'b0;
      cfifo_rden_r <= 1'b0;
      dfifo_rden_r <= '0;
    end else begin
      cfifo_rden_r <= go_s && (state_r == S_HDR);
      dfifo_rden_r <= (go_s && (state_r != S_HDR)) ? (NCH'(1) << chan_s) : '0;
      case (state_r)
        S_IDLE: begin
          if (!CFIFO_EMPTY && !OUT_AFULL) begin
            depth_r <= DRS_READDEPTH;
            list_r  <= list_s;
            n_en_r  <= n_en_s;
            wc_r    <= '0;
            sel_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= S_HDR;
          end
        end
        S_HDR, S_FLAG, S_STOP, S_DATA: begin
          if (go_s) begin
            if (last_s) begin
              wc_r <= '0;
              if (phase_done_s) begin
                sel_r   <= '0;
                state_r <= nxt_state_s;
                if (nxt_state_s == S_IDLE) begin
                  busy_r    <= 1'b0;
                  evt_cnt_r <= evt_cnt_r + 16'd1;
                end
              end else begin
                sel_r <= sel_r + CW'(1);
              end
            end else begin
              wc_r <= wc_r + LW'(1);
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding-read record; kept through reset so reads issued just before it still count.
  always_ff @(posedge CLK) begin
    pend_c_r <= cfifo_rden_r;
    pend_d_r <= dfifo_rden_r;
  end

  // Returned-word select: CFIFO first, then the lowest-index valid channel.
  always_comb begin
    word_s = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (DFIFO_VALID[i]) begin
        word_s = DFIFO_DOUT[i*DW +: DW];
      end else begin
        word_s = word_s;
      end
    end
    if (CFIFO_VALID) begin
      word_s = CFIFO_DOUT;
    end else begin
      word_s = word_s;
    end
    valid_any_s = CFIFO_VALID || (|DFIFO_VALID);
    multi_s     = ($countones({CFIFO_VALID, DFIFO_VALID}) > 32'sd1);
    orphan_s    = (CFIFO_VALID && !pend_c_r) || (|(DFIFO_VALID & ~pend_d_r));
  end

  // Output register stage and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_wren_r <= 1'b0;
      out_data_r <= '0;
      err_r      <= 1'b0;
    end else begin
      out_wren_r <= valid_any_s;
      if (valid_any_s) begin
        out_data_r <= word_s;
      end
      err_r <= err_r || multi_s || orphan_s;
    end
  end

  assign CFIFO_RDEN = cfifo_rden_r;
  assign DFIFO_RDEN = dfifo_rden_r;
  assign OUT_WREN   = out_wren_r;
  assign OUT_DATA   = out_data_r;
  assign BUSY       = busy_r;
  assign EVT_CNT    = evt_cnt_r;
  assign ERR        = err_r;

endmodule

// File: tb/tb_event_formatter_mc.sv
// Bench for event_formatter_mc: FIFO models, a word-sequence model derived from the
// channel-order/phase rules, and a per-cycle output compare process.
module tb_event_formatter_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic [12:0] DRS_READDEPTH;
  logic [7:0]  CH_MASK;
  logic        ORDER_MODE;
  logic        CFIFO_RDEN;
  logic        CFIFO_EMPTY;
  logic        CFIFO_VALID;
  logic [7:0]  CFIFO_DOUT;
  logic [7:0]  DFIFO_RDEN;
  logic [7:0]  DFIFO_EMPTY;
  logic [7:0]  DFIFO_VALID;
  logic [63:0] DFIFO_DOUT;
  logic        OUT_AFULL;
  logic        OUT_WREN;
  logic [7:0]  OUT_DATA;
  logic        BUSY;
  logic [15:0] EVT_CNT;
  logic        ERR;

  event_formatter_mc dut (
    .CLK(CLK), .RST(RST), .DRS_READDEPTH(DRS_READDEPTH), .CH_MASK(CH_MASK),
    .ORDER_MODE(ORDER_MODE), .CFIFO_RDEN(CFIFO_RDEN), .CFIFO_EMPTY(CFIFO_EMPTY),
    .CFIFO_VALID(CFIFO_VALID), .CFIFO_DOUT(CFIFO_DOUT), .DFIFO_RDEN(DFIFO_RDEN),
    .DFIFO_EMPTY(DFIFO_EMPTY), .DFIFO_VALID(DFIFO_VALID), .DFIFO_DOUT(DFIFO_DOUT),
    .OUT_AFULL(OUT_AFULL), .OUT_WREN(OUT_WREN), .OUT_DATA(OUT_DATA), .BUSY(BUSY),
    .EVT_CNT(EVT_CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] dfun(input int ch, input int n);
    return 8'((ch + 1) * 29 + n * 7);
  endfunction

  function automatic logic [7:0] hfun(input int n);
    return 8'(200 + n * 3);
  endfunction

  // FIFO models: channel FIFOs never run dry unless forced empty; header FIFO holds hdr_avail words.
  logic        cvalid_r = 1'b0;
  logic [7:0]  cdout_r  = 8'd0;
  logic [7:0]  dvalid_r = 8'd0;
  logic [63:0] ddout_r  = 64'd0;
  int          hdr_rd   = 0;
  int          hdr_avail = 0;
  int          rdptr [8] = '{default: 0};
  logic        force3   = 1'b0;
  logic [7:0]  inject_v = 8'd0;
  logic [7:0]  inject_d = 8'd0;
  logic [63:0] dout_s;

  always @(posedge CLK) begin
    cvalid_r <= CFIFO_RDEN;
    if (CFIFO_RDEN) begin
      cdout_r <= hfun(hdr_rd);
      hdr_rd  <= hdr_rd + 1;
    end
    for (int i = 0; i < 8; i++) begin
      dvalid_r[i] <= DFIFO_RDEN[i];
      if (DFIFO_RDEN[i]) begin
        ddout_r[i*8 +: 8] <= dfun(i, rdptr[i]);
        rdptr[i]          <= rdptr[i] + 1;
      end
    end
  end

  always_comb begin
    dout_s = ddout_r;
    if (inject_v[4]) dout_s[39:32] = inject_d;
  end

  assign CFIFO_EMPTY = (hdr_rd >= hdr_avail);
  assign CFIFO_VALID = cvalid_r;
  assign CFIFO_DOUT  = cdout_r;
  assign DFIFO_EMPTY = {4'b0000, force3, 3'b000};
  assign DFIFO_VALID = dvalid_r | inject_v;
  assign DFIFO_DOUT  = dout_s;

  // Behavioural model: expected output word stream.
  logic [7:0] exp_q[$];
  int         mrd [8] = '{default: 0};
  int         mhdr = 0;

  task automatic build_event(input int depth, input logic [7:0] mask, input logic ord);
    int lst[$];
    int n;
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back(hfun(mhdr));
      mhdr++;
    end
    if (ord) begin
      for (int p = 0; p < 2; p++)
        for (int c = p; c < 8; c += 2)
          if (mask[c]) lst.push_back(c);
    end else begin
      for (int c = 0; c < 8; c++)
        if (mask[c]) lst.push_back(c);
    end
    for (int ph = 0; ph < 3; ph++) begin
      n = (ph == 2) ? depth * 4 : 2;
      foreach (lst[x])
        for (int k = 0; k < n; k++) begin
          exp_q.push_back(dfun(lst[x], mrd[lst[x]]));
          mrd[lst[x]]++;
        end
    end
  endtask

  // Compare process: output words against the model, strobe legality against backpressure.
  logic       chk_en = 1'b1;
  logic       afull_prev = 1'b0;
  int         wr_total = 0;
  logic [7:0] out_log [4096];
  logic [7:0] e;

  always @(negedge CLK) begin
    if (!RST && ({CFIFO_RDEN, DFIFO_RDEN} != 9'd0)) begin
      checks++;
      if (afull_prev || $countones({CFIFO_RDEN, DFIFO_RDEN}) != 1) begin
        errors++;
        $display("FAIL strobe: rden=%b/%b afull_prev=%b required one strobe with afull_prev=0",
                 CFIFO_RDEN, DFIFO_RDEN, afull_prev);
      end
    end
    afull_prev = OUT_AFULL;
    if (OUT_WREN) begin
      if (wr_total < 4096) out_log[wr_total] = OUT_DATA;
      wr_total++;
      if (chk_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_word: got %02h required no word", OUT_DATA);
        end else begin
          e = exp_q.pop_front();
          if (OUT_DATA !== e) begin
            errors++;
            $display("FAIL out_word #%0d: got %02h required %02h", wr_total - 1, OUT_DATA, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  int         cyc = 0;
  logic       stall_en = 1'b0;
  logic [7:0] rden_seen = 8'd0;
  int         exp_evt = 0;

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (stall_en) begin
      OUT_AFULL = (cyc % 3 == 0);
      force3    = ($urandom_range(0, 3) == 0);
    end
    rden_seen |= DFIFO_RDEN;
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int n = 0;
    while (BUSY !== lvl && n < limit) begin
      step();
      n++;
    end
    chk(name, 32'(BUSY), 32'(lvl));
  endtask

  task automatic run_event(input string name, input int depth, input logic [7:0] mask,
                           input logic ord, input logic stall, input logic chg, input int nwords);
    int start;
    DRS_READDEPTH = 13'(depth);
    CH_MASK       = mask;
    ORDER_MODE    = ord;
    build_event(depth, mask, ord);
    start     = wr_total;
    rden_seen = 8'd0;
    stall_en  = stall;
    hdr_avail = hdr_avail + 32;
    wait_busy(1'b1, 50, {name, "_busy_rise"});
    if (chg) begin
      repeat (10) step();
      DRS_READDEPTH = 13'd5;
      CH_MASK       = 8'h07;
    end
    wait_busy(1'b0, 6000, {name, "_busy_fall"});
    stall_en  = 1'b0;
    OUT_AFULL = 1'b0;
    force3    = 1'b0;
    repeat (8) step();
    exp_evt++;
    chk({name, "_words"}, 32'(wr_total - start), 32'(nwords));
    chk({name, "_model_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_evt_cnt"}, 32'(EVT_CNT), 32'(exp_evt));
    chk({name, "_err"}, 32'(ERR), 32'd0);
  endtask

  int base;

  initial begin
    RST = 1'b1;
    DRS_READDEPTH = 13'd0;
    CH_MASK = 8'h00;
    ORDER_MODE = 1'b0;
    OUT_AFULL = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_evt", 32'(EVT_CNT), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_wren", 32'(OUT_WREN), 32'd0);
    chk("rst_data", 32'(OUT_DATA), 32'd0);
    chk("rst_strobes", 32'({CFIFO_RDEN, DFIFO_RDEN}), 32'd0);
    RST = 1'b0;
    repeat (2) step();

    base = wr_total;
    run_event("t1_ord1", 2, 8'hFF, 1'b1, 1'b0, 1'b0, 128);
    chk("t1_first_flag", 32'(out_log[base + 32]), 32'h1D);
    chk("t1_ch2_flag", 32'(out_log[base + 34]), 32'h57);
    chk("t1_ch4_flag", 32'(out_log[base + 36]), 32'h91);

    base = wr_total;
    run_event("t2_mask05", 1, 8'h05, 1'b0, 1'b0, 1'b0, 48);
    chk("t2_rden_seen", 32'(rden_seen), 32'h05);
    chk("t2_ch2_flag", 32'(out_log[base + 34]), 32'hAB);

    run_event("t3_depth0", 0, 8'hFF, 1'b0, 1'b0, 1'b0, 64);
    chk("t3_busy_idle", 32'(BUSY), 32'd0);

    run_event("t4_stall", 2, 8'hFF, 1'b1, 1'b1, 1'b0, 128);

    run_event("t5_midchg", 2, 8'hFF, 1'b0, 1'b0, 1'b1, 128);
    run_event("t6_newcfg", 5, 8'h07, 1'b0, 1'b0, 1'b0, 104);

    run_event("t7_mask0", 2, 8'h00, 1'b0, 1'b0, 1'b0, 32);

    exp_q.push_back(8'hA5);
    inject_d = 8'hA5;
    inject_v = 8'h10;
    step();
    inject_v = 8'h00;
    repeat (2) step();
    chk("inj_err_set", 32'(ERR), 32'd1);
    repeat (10) step();
    chk("inj_err_sticky", 32'(ERR), 32'd1);
    chk("inj_model_drained", 32'(exp_q.size()), 32'd0);
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    step();
    chk("inj_err_cleared", 32'(ERR), 32'd0);
    chk("inj_evt_cleared", 32'(EVT_CNT), 32'd0);

    chk_en = 1'b0;
    DRS_READDEPTH = 13'd2;
    CH_MASK = 8'hFF;
    ORDER_MODE = 1'b0;
    base = wr_total;
    hdr_avail = hdr_avail + 32;
    for (int n = 0; n < 2000 && (wr_total - base) < 70; n++) step();
    chk("mid_reached_data", 32'((wr_total - base) >= 70), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_busy", 32'(BUSY), 32'd0);
    chk("mid_strobes", 32'({CFIFO_RDEN, DFIFO_RDEN}), 32'd0);
    step();
    chk("mid_inflight_fwd", 32'(OUT_WREN), 32'd1);
    repeat (4) step();
    chk("mid_err", 32'(ERR), 32'd0);
    chk("mid_idle", 32'(BUSY), 32'd0);
    chk("mid_evt", 32'(EVT_CNT), 32'd0);
    chk("mid_strobes_idle", 32'({CFIFO_RDEN, DFIFO_RDEN}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
